// File: rtl/vga_pkg.sv
// Shared VGA definitions: RGB565 colour constants, pattern mode encodings and default active sizes.
package vga_pkg;

   localparam int unsigned COORD_W      = 10;
   localparam int unsigned H_ACTIVE_DEF = 640;
   localparam int unsigned V_ACTIVE_DEF = 480;

   typedef struct packed {
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
   } rgb565_t;

   localparam rgb565_t RGB_WHITE   = 16'hFFFF;
   localparam rgb565_t RGB_YELLOW  = 16'hFFE0;
   localparam rgb565_t RGB_CYAN    = 16'h07FF;
   localparam rgb565_t RGB_GREEN   = 16'h07E0;
   localparam rgb565_t RGB_MAGENTA = 16'hF81F;
   localparam rgb565_t RGB_RED     = 16'hF800;
   localparam rgb565_t RGB_BLUE    = 16'h001F;
   localparam rgb565_t RGB_BLACK   = 16'h0000;

   typedef enum logic [1:0] {
      MODE_BARS  = 2'd0,
      MODE_CHECK = 2'd1,
      MODE_GRAD  = 2'd2,
      MODE_BOX   = 2'd3
   } mode_e;

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position: advances bx/by once per frame_start and reflects off the active-area edges.
module vga_box_mover
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
   parameter int unsigned BOX_SIZE = 32,
   parameter int unsigned BOX_STEP = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               frame_start,
   output logic [COORD_W-1:0] bx,
   output logic [COORD_W-1:0] by
);

   localparam logic [COORD_W-1:0] STEP    = COORD_W'(BOX_STEP);
   localparam logic [COORD_W-1:0] X_MAX   = COORD_W'(H_ACTIVE - BOX_SIZE);
   localparam logic [COORD_W-1:0] Y_MAX   = COORD_W'(V_ACTIVE - BOX_SIZE);
   localparam logic [COORD_W-1:0] X_TURN  = COORD_W'(H_ACTIVE - BOX_SIZE - BOX_STEP);
   localparam logic [COORD_W-1:0] Y_TURN  = COORD_W'(V_ACTIVE - BOX_SIZE - BOX_STEP);

   logic               dir_x;
   logic               dir_y;
   logic [COORD_W-1:0] bx_nxt_c;
   logic [COORD_W-1:0] by_nxt_c;
   logic               dir_x_nxt_c;
   logic               dir_y_nxt_c;

   // One axis of the bounce: clamp onto the edge and reverse when the next step would reach it.
   function automatic logic [COORD_W:0] step_axis(
      input logic [COORD_W-1:0] pos,
      input logic               dir,
      input logic [COORD_W-1:0] turn,
      input logic [COORD_W-1:0] max_pos
   );
      logic               nxt_dir;
      logic [COORD_W-1:0] nxt_pos;
      nxt_dir = dir;
      nxt_pos = pos;
      if (dir) begin
         if (pos >= turn) begin
            nxt_pos = max_pos;
            nxt_dir = 1'b0;
         end else begin
            nxt_pos = pos + STEP;
         end
      end else begin
         if (pos <= STEP) begin
            nxt_pos = '0;
            nxt_dir = 1'b1;
         end else begin
            nxt_pos = pos - STEP;
         end
      end
      return {nxt_dir, nxt_pos};
   endfunction

   always_comb begin
      {dir_x_nxt_c, bx_nxt_c} = step_axis(bx, dir_x, X_TURN, X_MAX);
      {dir_y_nxt_c, by_nxt_c} = step_axis(by, dir_y, Y_TURN, Y_MAX);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bx    <= '0;
         by    <= '0;
         dir_x <= 1'b1;
         dir_y <= 1'b1;
      end else if (frame_start) begin
         bx    <= bx_nxt_c;
         by    <= by_nxt_c;
         dir_x <= dir_x_nxt_c;
         dir_y <= dir_y_nxt_c;
      end
   end

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern source: frame-latched mode select, four-way pattern mux and a single output register stage.
module vga_pattern_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
   parameter int unsigned BOX_SIZE = 32,
   parameter int unsigned BOX_STEP = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         mode_sel,
   input  logic               frame_start,
   input  logic               de_in,
   input  logic               hsync_in,
   input  logic               vsync_in,
   input  logic [COORD_W-1:0] x_in,
   input  logic [COORD_W-1:0] y_in,
   output logic [4:0]         R,
   output logic [5:0]         G,
   output logic [4:0]         B,
   output logic               HSYNC,
   output logic               VSYNC,
   output logic               de_out
);

   localparam int unsigned BAR_W = H_ACTIVE / 8;

   mode_e              mode_q;
   logic [COORD_W-1:0] bx;
   logic [COORD_W-1:0] by;
   logic [2:0]         bar_idx_c;
   rgb565_t            bar_c;
   logic               in_box_c;
   rgb565_t            pix_c;

   // Mode only changes on frame boundaries so a pattern never tears mid-frame.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mode_q <= MODE_BARS;
      end else if (frame_start) begin
         mode_q <= mode_e'(mode_sel);
      end
   end

   vga_box_mover #(
      .H_ACTIVE (H_ACTIVE),
      .V_ACTIVE (V_ACTIVE),
      .BOX_SIZE (BOX_SIZE),
      .BOX_STEP (BOX_STEP)
   ) u_box_mover (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_start (frame_start),
      .bx          (bx),
      .by          (by)
   );

   always_comb begin
      bar_idx_c = 3'(x_in / COORD_W'(BAR_W));
      case (bar_idx_c)
         3'd0:    bar_c = RGB_WHITE;
         3'd1:    bar_c = RGB_YELLOW;
         3'd2:    bar_c = RGB_CYAN;
         3'd3:    bar_c = RGB_GREEN;
         3'd4:    bar_c = RGB_MAGENTA;
         3'd5:    bar_c = RGB_RED;
         3'd6:    bar_c = RGB_BLUE;
         default: bar_c = RGB_BLACK;
      endcase
   end

   // Compare one bit wider so bx+BOX_SIZE cannot wrap near the right/bottom edge.
   always_comb begin
      in_box_c = ({1'b0, x_in} >= {1'b0, bx}) &&
                 ({1'b0, x_in} <  ((COORD_W + 1)'(bx) + (COORD_W + 1)'(BOX_SIZE))) &&
                 ({1'b0, y_in} >= {1'b0, by}) &&
                 ({1'b0, y_in} <  ((COORD_W + 1)'(by) + (COORD_W + 1)'(BOX_SIZE)));
   end

   always_comb begin
      pix_c = RGB_BLACK;
      if (de_in) begin
         case (mode_q)
            MODE_BARS:  pix_c = bar_c;
            MODE_CHECK: pix_c = (x_in[5] ^ y_in[5]) ? RGB_BLACK : RGB_WHITE;
            MODE_GRAD: begin
               pix_c.r = x_in[8:4];
               pix_c.g = y_in[8:3];
               pix_c.b = x_in[4:0];
            end
            MODE_BOX:   pix_c = in_box_c ? RGB_RED : RGB_BLUE;
            default:    pix_c = RGB_BLACK;
         endcase
      end
   end

   // Colour, syncs and de share one register stage so they stay aligned.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         R      <= '0;
         G      <= '0;
         B      <= '0;
         HSYNC  <= 1'b1;
         VSYNC  <= 1'b1;
         de_out <= 1'b0;
      end else begin
         R      <= pix_c.r;
         G      <= pix_c.g;
         B      <= pix_c.b;
         HSYNC  <= hsync_in;
         VSYNC  <= vsync_in;
         de_out <= de_in;
      end
   end

endmodule

// File: doc/vga_pattern_gen.md
# vga_pattern_gen

Test-pattern source for the VGA output path: consumes pixel coordinates, data-enable and syncs from the timing stage and produces registered RGB565 plus delayed syncs for the `vga_top` output pins. It provides four selectable patterns, one of them an animated bouncing box updated once per frame. It sits directly upstream of the R/G/B/HSYNC/VSYNC pins on the 50 MHz pixel-path clock.

## Interface
- `H_ACTIVE`, 640: active pixels per line.
- `V_ACTIVE`, 480: active lines per frame.
- `BOX_SIZE`, 32: bouncing-box edge length, in pixels.
- `BOX_STEP`, 2: box displacement per frame, per axis, in pixels.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `mode_sel` in 2: requested pattern; 0 bars, 1 checker, 2 gradient, 3 box.
- `frame_start` in 1: one-cycle pulse at the start of each frame, from the timing stage.
- `de_in` in 1: active-video enable.
- `hsync_in` in 1: horizontal sync from the timing stage; active-low.
- `vsync_in` in 1: vertical sync from the timing stage; active-low.
- `x_in` in 10: pixel column, 0..H_ACTIVE-1 while `de_in`=1.
- `y_in` in 10: pixel row, 0..V_ACTIVE-1 while `de_in`=1.
- `R` out 5: red component.
- `G` out 6: green component.
- `B` out 5: blue component.
- `HSYNC` out 1: `hsync_in` delayed one cycle.
- `VSYNC` out 1: `vsync_in` delayed one cycle.
- `de_out` out 1: `de_in` delayed one cycle.

## Operation
- Mode register `mode_q`:
  - Loads `mode_sel` only on cycles where `frame_start`=1.
  - A change in `mode_sel` mid-frame is ignored until the next `frame_start`.
- `de_in`=0: RGB output is 0,0,0.
- Mode 0, colour bars:
  - Bar index = `x_in`/(H_ACTIVE/8), giving 80-px bars at default.
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black.
  - Full-scale components: R=31, G=63, B=31.
- Mode 1, checker: `x_in[5]`^`y_in[5]` = 0 gives white, 1 gives black.
- Mode 2, gradient: R=`x_in[8:4]`, G=`y_in[8:3]`, B=`x_in[4:0]`; bits wrap naturally.
- Mode 3, box:
  - Pixel inside the box is red (31,0,0); elsewhere blue (0,0,31).
  - Inside means bx ≤ x < bx+BOX_SIZE and by ≤ y < by+BOX_SIZE.
- Box state:
  - Registers: bx, by (10 b) and dir_x, dir_y (1 = increasing).
  - Updates on every `frame_start`, regardless of mode.
  - X axis, dir_x=1: if bx ≥ H_ACTIVE-BOX_SIZE-BOX_STEP, then bx←H_ACTIVE-BOX_SIZE and dir_x←0; else bx←bx+BOX_STEP.
  - X axis, dir_x=0: if bx ≤ BOX_STEP, then bx←0 and dir_x←1; else bx←bx-BOX_STEP.
  - Y axis: identical rule using V_ACTIVE, by and dir_y.
- `frame_start` coincident with `de_in`=1: the pixel on that cycle uses the old `mode_q` and old box position; the new values apply from the next cycle.

## Timing
- Latency: exactly 1 clock from inputs to R/G/B/HSYNC/VSYNC/de_out; all outputs are registered.
- Syncs, `de_out` and colour stay aligned; no relative skew is permitted.
- Reset values, applied on the first rising edge with `rst_n`=0:
  - R=G=B=0, `de_out`=0, HSYNC=1, VSYNC=1.
  - `mode_q`=0.
  - bx=by=0, dir_x=dir_y=1.
- Reset mid-frame: the outputs above are forced on the next edge; normal output resumes on the first edge after `rst_n`=1.
- No handshake: the block free-runs, one pixel per clock.

## Structure
- Shared package `vga_pkg` holds:
  - RGB565 colour constants: white, yellow, cyan, green, magenta, red, blue, black.
  - Mode encodings `MODE_BARS`, `MODE_CHECK`, `MODE_GRAD`, `MODE_BOX`.
  - Default H/V active sizes, shared with the timing stage.
- Sub-module `vga_box_mover` contains bx/by/dir_x/dir_y and the bounce logic, clocked by `frame_start`.
- The top level holds the mode register, pattern mux and output register stage.

## Test plan
- Reset held, then released: R/G/B=0, HSYNC=VSYNC=1, `de_out`=0; with `de_in`=0 afterwards, RGB stays 0.
- Mode 0 after `frame_start`: x=0 → (31,63,31); x=85 → (31,63,0); x=639 → (0,0,0); each appears 1 cycle after input, with HSYNC a 1-cycle copy of `hsync_in`.
- Mode 1: (x=0,y=0) → white; (32,0) → black; (32,32) → white. Set `mode_sel`=2 mid-frame: output stays checker until the next `frame_start`.
- Mode 2: (x=0x1F0, y=0x0F8) → R=31, G=31, B=16.
- Mode 3 from reset: (0,0) → red, (32,0) → blue. After 1 `frame_start`: bx=by=2, so (33,33) → red and (1,1) → blue.
- Bounce: 304 `frame_start` pulses from reset → bx=608, dir_x=0 (right edge). 120 more → bx=368. Y axis: by=448 at pulse 224, then 446.
